// File: rtl/bit8_mem_if.sv
// bit8_mem_if
//   Core-side bus of the bit8core memory responder: 8-bit address, a shared
//   bidirectional data bus and a read/write strobe.
//
//   The shared bus is resolved in one place (the `data` net below). Each side
//   presents its own drive value and output enable, and `data` carries
//   whichever side is enabled. It floats (Z) when neither side drives.
//
//   Signals
//     addr     master -> slave   bus address
//     rw       master -> slave   1 = write, 0 = read
//     wr_data  master            value the master puts on the bus
//     wr_oe    master            master drives the bus
//     rd_data  slave             value the slave puts on the bus
//     rd_oe    slave             slave drives the bus (read data)
//     data     both              resolved bidirectional bus
interface bit8_mem_if;
  logic [7:0] addr;
  logic       rw;
  logic [7:0] wr_data;
  logic       wr_oe;
  logic [7:0] rd_data;
  logic       rd_oe;
  wire  [7:0] data;

  // If both sides drive at once, the slave's read data wins. Both sides
  // driving together is a protocol error on the master's part.
  assign data = rd_oe ? rd_data : (wr_oe ? wr_data : 8'bz);

  modport master (output addr, output rw, output wr_data, output wr_oe,
                  input data, input rd_oe);
  modport slave  (input addr, input rw, input data,
                  output rd_data, output rd_oe);
endinterface

// File: rtl/bit8_mem_responder.sv
// bit8_mem_responder
//   Memory-side responder for one bit8core. It holds a 256x8 RAM and works in
//   three phases:
//     CLEAR  zero the RAM, one byte per cycle (256 cycles)
//     LOAD   accept LOAD_LEN bytes from a byte-stream loader into addr 0 upward
//     RUN    release the core and serve its bus with combinational reads,
//            plus two I/O bytes at the top of the map
//   The core is held in reset (core_rst=1) in every phase except RUN.
//
//   Ports
//     clk, rst              clock and synchronous active-high reset
//     bus (slave)           core bus: addr, rw, data (driven only for reads)
//     core_rst              core reset hold, low only in RUN
//     ld_data/ld_valid      loader byte stream, accepted when ld_ready=1
//     ld_ready              high in LOAD
//     out_data/out_stb      output port register and its write pulse
//     in_data/in_valid      input port value and its valid flag
//     in_ack                pulse after a qualified read of the input port
module bit8_mem_responder #(
  parameter int         LOAD_LEN = 256,
  parameter logic [7:0] OUT_ADDR = 8'hFE,
  parameter logic [7:0] IN_ADDR  = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  bit8_mem_if.slave        bus,
  output logic             core_rst,
  input  logic [7:0]       ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic [7:0]       out_data,
  output logic             out_stb,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ack
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // The load pointer is 9 bits wide, so LOAD_LEN=256 ends on pointer value
  // 255 without the pointer wrapping back onto address 0.
  localparam logic [8:0] LD_LAST = 9'(LOAD_LEN - 1);

  logic [1:0] state_reg, state_next;
  logic [7:0] clr_ptr_reg, clr_ptr_next;
  logic [8:0] ld_ptr_reg, ld_ptr_next;
  logic [7:0] out_data_reg, out_data_next;
  logic       out_stb_reg, out_stb_next;
  logic       in_ack_reg, in_ack_next;

  logic [7:0] mem [0:255];

  // All three phases share one write port: the clear sweep, the loader and
  // core writes. Only one of them is active in any given state.
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  always_comb begin
    state_next    = state_reg;
    clr_ptr_next  = clr_ptr_reg;
    ld_ptr_next   = ld_ptr_reg;
    out_data_next = out_data_reg;
    out_stb_next  = 1'b0;
    in_ack_next   = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = 8'h00;
    mem_wdata     = 8'h00;

    case (state_reg)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_ptr_reg;
        clr_ptr_next = clr_ptr_reg + 8'd1;
        if (clr_ptr_reg == 8'hFF)
          state_next = ST_LOAD;
      end

      ST_LOAD: begin
        if (ld_valid) begin
          mem_we      = 1'b1;
          mem_waddr   = ld_ptr_reg[7:0];
          mem_wdata   = ld_data;
          ld_ptr_next = ld_ptr_reg + 9'd1;
          if (ld_ptr_reg == LD_LAST)
            state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.rw) begin
          // A write to the input port is silently dropped. A write to the
          // output port updates the register and leaves the RAM alone.
          if (bus.addr == IN_ADDR) begin
            mem_we = 1'b0;
          end else if (bus.addr == OUT_ADDR) begin
            out_data_next = bus.data;
            out_stb_next  = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = bus.addr;
            mem_wdata = bus.data;
          end
        end else if (bus.addr == IN_ADDR && in_valid) begin
          in_ack_next = 1'b1;
        end
      end

      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_ptr_reg  <= 8'h00;
      ld_ptr_reg   <= 9'h000;
      out_data_reg <= 8'h00;
      out_stb_reg  <= 1'b0;
      in_ack_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_ptr_reg  <= clr_ptr_next;
      ld_ptr_reg   <= ld_ptr_next;
      out_data_reg <= out_data_next;
      out_stb_reg  <= out_stb_next;
      in_ack_reg   <= in_ack_next;
    end
  end

  // Reset wins over any loader or core write arriving on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Reads are combinational, so the core samples the data on the edge that
  // ends its read cycle. The RAM cells under the I/O addresses stay hidden.
  always_comb begin
    bus.rd_oe   = (state_reg == ST_RUN) && !bus.rw;
    bus.rd_data = (bus.addr == IN_ADDR)  ? in_data :
                  (bus.addr == OUT_ADDR) ? out_data_reg :
                  mem[bus.addr];
  end

  assign core_rst = (state_reg != ST_RUN);
  assign ld_ready = (state_reg == ST_LOAD);
  assign out_data = out_data_reg;
  assign out_stb  = out_stb_reg;
  assign in_ack   = in_ack_reg;

endmodule

// File: tb/tb_bit8_mem_responder.sv
module tb_bit8_mem_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic       core_rst;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] out_data;
  logic       out_stb;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ack;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit8_mem_if bus ();

  bit8_mem_responder #(.LOAD_LEN(4), .OUT_ADDR(8'hFE), .IN_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst), .bus(bus), .core_rst(core_rst),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .out_data(out_data), .out_stb(out_stb),
    .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack)
  );

  always #5 clk = ~clk;

  // Behavioural model of what the block must look like: a count of clear
  // cycles still to go, how many loader bytes have arrived, whether the core
  // runs, the memory image and the I/O outputs.
  int         m_clear_left = 256;
  int         m_loaded = 0;
  bit         m_running = 1'b0;
  logic [7:0] m_mem [256];
  logic [7:0] m_out = 8'h00;
  bit         m_stb = 1'b0;
  bit         m_ack = 1'b0;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == 8'hFF) return in_data;
    if (a == 8'hFE) return m_out;
    return m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_clear_left = 256;
      m_loaded = 0;
      m_running = 1'b0;
      m_out = 8'h00;
      m_stb = 1'b0;
      m_ack = 1'b0;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    end else begin
      m_stb = 1'b0;
      m_ack = 1'b0;
      if (m_clear_left > 0) begin
        m_clear_left--;
      end else if (!m_running) begin
        if (ld_valid) begin
          m_mem[m_loaded] = ld_data;
          m_loaded++;
          if (m_loaded == 4) m_running = 1'b1;
        end
      end else if (bus.rw) begin
        if (bus.addr == 8'hFE) begin
          m_out = bus.wr_data;
          m_stb = 1'b1;
        end else if (bus.addr != 8'hFF) begin
          m_mem[bus.addr] = bus.wr_data;
        end
      end else if (bus.addr == 8'hFF && in_valid) begin
        m_ack = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("core_rst", {31'd0, core_rst}, {31'd0, !m_running});
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, (m_clear_left == 0) && !m_running});
      chk("rd_oe", {31'd0, bus.rd_oe}, {31'd0, m_running && !bus.rw});
      if (m_running && !bus.rw)
        chk("bus_data", {24'd0, bus.data}, {24'd0, m_read(bus.addr)});
      chk("out_data", {24'd0, out_data}, {24'd0, m_out});
      chk("out_stb", {31'd0, out_stb}, {31'd0, m_stb});
      chk("in_ack", {31'd0, in_ack}, {31'd0, m_ack});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] load_bytes [4];
  int nonzero;

  initial begin
    load_bytes[0] = 8'h81; load_bytes[1] = 8'hC6;
    load_bytes[2] = 8'h40; load_bytes[3] = 8'h10;
    rst = 1'b1; ld_data = 8'h00; ld_valid = 1'b0;
    in_data = 8'h00; in_valid = 1'b0;
    bus.addr = 8'h00; bus.rw = 1'b0; bus.wr_data = 8'h00; bus.wr_oe = 1'b0;

    // T1: reset, 256 clear cycles with the loader already offering a byte
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    ld_valid = 1'b1; ld_data = 8'hEE;
    #1;
    chk("t1_core_rst", {31'd0, core_rst}, 32'd1);
    chk("t1_ld_ready_start", {31'd0, ld_ready}, 32'd0);
    repeat (255) tick();
    #1;
    chk("t1_ld_ready_255", {31'd0, ld_ready}, 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("t1_ld_ready_256", {31'd0, ld_ready}, 32'd1);
    nonzero = 0;
    for (int i = 0; i < 256; i++) if (dut.mem[i] !== 8'h00) nonzero++;
    chk("t1_mem_zero", nonzero, 32'd0);

    // T2: four loader bytes separated by idle cycles
    for (int k = 0; k < 4; k++) begin
      tick();
      ld_valid = 1'b1; ld_data = load_bytes[k];
      tick();
      ld_valid = 1'b0;
    end
    #1;
    chk("t2_core_rst", {31'd0, core_rst}, 32'd0);
    chk("t2_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("t2_mem0", {24'd0, dut.mem[0]}, 32'h81);
    chk("t2_mem1", {24'd0, dut.mem[1]}, 32'hC6);
    chk("t2_mem2", {24'd0, dut.mem[2]}, 32'h40);
    chk("t2_mem3", {24'd0, dut.mem[3]}, 32'h10);

    // T3: write 5A to 20, read it straight back
    bus.rw = 1'b1; bus.wr_oe = 1'b1; bus.addr = 8'h20; bus.wr_data = 8'h5A;
    tick();
    bus.rw = 1'b0; bus.wr_oe = 1'b0;
    #1;
    chk("t3_read20", {24'd0, bus.data}, 32'h5A);
    chk("t3_mem21", {24'd0, dut.mem[8'h21]}, 32'h00);

    // T4: output port, single write then back-to-back writes
    bus.rw = 1'b1; bus.wr_oe = 1'b1; bus.addr = 8'hFE; bus.wr_data = 8'h3C;
    tick();
    bus.rw = 1'b0; bus.wr_oe = 1'b0; bus.addr = 8'h00;
    #1;
    chk("t4_out_data", {24'd0, out_data}, 32'h3C);
    chk("t4_out_stb_hi", {31'd0, out_stb}, 32'd1);
    tick();
    bus.addr = 8'hFE;
    #1;
    chk("t4_out_stb_lo", {31'd0, out_stb}, 32'd0);
    chk("t4_readFE", {24'd0, bus.data}, 32'h3C);
    bus.rw = 1'b1; bus.wr_oe = 1'b1; bus.wr_data = 8'h11;
    tick();
    bus.wr_data = 8'h22;
    tick();
    bus.rw = 1'b1; bus.addr = 8'hFF; bus.wr_data = 8'h77;
    #1;
    chk("t4_b2b_stb", {31'd0, out_stb}, 32'd1);
    chk("t4_b2b_data", {24'd0, out_data}, 32'h22);
    tick();
    bus.rw = 1'b0; bus.wr_oe = 1'b0; bus.addr = 8'h00;
    #1;
    chk("t4_inaddr_write_dropped", {24'd0, dut.mem[8'hFF]}, 32'h00);

    // T5: input port with and without in_valid
    in_data = 8'hA7; in_valid = 1'b1; bus.addr = 8'hFF;
    #1;
    chk("t5_readFF", {24'd0, bus.data}, 32'hA7);
    tick();
    bus.addr = 8'h00;
    #1;
    chk("t5_in_ack_hi", {31'd0, in_ack}, 32'd1);
    tick();
    in_valid = 1'b0; bus.addr = 8'hFF;
    #1;
    chk("t5_in_ack_lo", {31'd0, in_ack}, 32'd0);
    tick();
    #1;
    chk("t5_no_ack_invalid", {31'd0, in_ack}, 32'd0);
    chk("t5_unqualified_data", {24'd0, bus.data}, 32'hA7);

    // T6: reset arrives together with a core write to 20
    bus.rw = 1'b1; bus.wr_oe = 1'b1; bus.addr = 8'h20; bus.wr_data = 8'h99;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.rw = 1'b0; bus.wr_oe = 1'b0;
    #1;
    chk("t6_core_rst", {31'd0, core_rst}, 32'd1);
    chk("t6_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("t6_write_dropped", {24'd0, dut.mem[8'h20]}, 32'h5A);
    repeat (255) tick();
    #1;
    chk("t6_ld_ready_255", {31'd0, ld_ready}, 32'd0);
    tick();
    #1;
    chk("t6_ld_ready_256", {31'd0, ld_ready}, 32'd1);
    chk("t6_mem20_cleared", {24'd0, dut.mem[8'h20]}, 32'h00);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
